// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register chain: default widths, named
// control-bit positions and a packed beat type for users that pack payloads.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 4;

    // Bit positions inside the control vector carried alongside the payload.
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_JUMP     = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } pipe_beat_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One 2-entry skid stage: a main register driving the output and a skid
// register that catches one beat while the output is stalled. The upstream
// ready is registered, so there is no combinational path from i_ready to o_ready.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_main_valid, r_skid_valid, r_ready;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;

    logic              w_main_valid_d, w_skid_valid_d;
    logic [DATA_W-1:0] w_main_data_d, w_skid_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d, w_skid_ctrl_d;
    logic              w_in_xfer, w_out_xfer;

    // Next-state: refill main from skid first, otherwise from the input.
    always_comb begin
        w_in_xfer      = i_valid && r_ready;
        w_out_xfer     = r_main_valid && i_ready;
        w_main_valid_d = r_main_valid;
        w_main_data_d  = r_main_data;
        w_main_ctrl_d  = r_main_ctrl;
        w_skid_valid_d = r_skid_valid;
        w_skid_data_d  = r_skid_data;
        w_skid_ctrl_d  = r_skid_ctrl;
        if (i_flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
            w_main_ctrl_d  = '0;
            w_skid_ctrl_d  = '0;
        end else if (!r_main_valid || w_out_xfer) begin
            if (r_skid_valid) begin
                // Skid full implies r_ready was low, so no input beat this cycle.
                w_main_valid_d = 1'b1;
                w_main_data_d  = r_skid_data;
                w_main_ctrl_d  = r_skid_ctrl;
                w_skid_valid_d = 1'b0;
            end else if (w_in_xfer) begin
                w_main_valid_d = 1'b1;
                w_main_data_d  = i_data;
                w_main_ctrl_d  = i_ctrl;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_valid_d = 1'b1;
            w_skid_data_d  = i_data;
            w_skid_ctrl_d  = i_ctrl;
        end
    end

    // State registers with synchronous active-low reset; ready held low in reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_main_data  <= w_main_data_d;
            r_skid_data  <= w_skid_data_d;
            r_main_ctrl  <= w_main_ctrl_d;
            r_skid_ctrl  <= w_skid_ctrl_d;
            r_ready      <= !w_skid_valid_d;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;
    assign o_ctrl  = r_main_ctrl;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH skid stages between two datapath stages, with
// flush, an occupancy counter and control bits masked to zero when invalid.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEPTH  = 1,
    localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  occupancy
);

    // Link k sits in front of stage k; link DEPTH is the chain head.
    logic [DEPTH:0]             w_valid;
    logic [DEPTH:0]             w_ready;
    logic [DEPTH:0][DATA_W-1:0] w_data;
    logic [DEPTH:0][CTRL_W-1:0] w_ctrl;

    logic             w_in_xfer, w_out_xfer;
    logic [CNT_W-1:0] r_occ, w_occ_d;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign w_ctrl[0]      = in_ctrl;
    assign in_ready       = w_ready[0];
    assign w_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_skid_slot #(
            .DATA_W(DATA_W),
            .CTRL_W(CTRL_W)
        ) u_slot (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_flush(flush),
            .i_valid(w_valid[g]),
            .o_ready(w_ready[g]),
            .i_data (w_data[g]),
            .i_ctrl (w_ctrl[g]),
            .o_valid(w_valid[g+1]),
            .i_ready(w_ready[g+1]),
            .o_data (w_data[g+1]),
            .o_ctrl (w_ctrl[g+1])
        );
    end

    assign out_valid = w_valid[DEPTH];
    assign out_data  = w_data[DEPTH];
    assign out_ctrl  = out_valid ? w_ctrl[DEPTH] : '0;
    assign occupancy = r_occ;

    // Occupancy next-state: +1 per accepted beat, -1 per consumed beat.
    always_comb begin
        w_in_xfer  = in_valid && in_ready;
        w_out_xfer = out_valid && out_ready;
        w_occ_d    = r_occ;
        if (flush) begin
            w_occ_d = '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            w_occ_d = r_occ + CNT_W'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            w_occ_d = r_occ - CNT_W'(1);
        end
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a DEPTH=2 and a DEPTH=1 instance share stimulus.
// Each has a FIFO model (circular array) checked every cycle at the falling edge,
// plus directed literal expectations from the driver.
module tb_pipe_stage_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;

    logic        ir2, ov2, ir1, ov1;
    logic [31:0] od2, od1;
    logic [3:0]  oc2, oc1;
    logic [2:0]  occ2;
    logic [1:0]  occ1;

    int checks = 0;
    int errors = 0;

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(4), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ctrl(oc2),
        .occupancy(occ2)
    );

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(4), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // ---------------- FIFO model, index 0 = DEPTH 2, index 1 = DEPTH 1 ----------
    logic [35:0] m_mem [2][16];
    int          m_head [2];
    int          m_cnt [2];
    bit          m_in_rst [2];
    bit          m_exp_rdy [2];
    bit          m_started = 1'b0;

    task automatic model_step(input int k, input bit do_check, input logic ov,
                              input logic [31:0] od, input logic [3:0] oc,
                              input int occ, input logic ir);
        logic [35:0] hd;
        int          cap;
        bit          in_x, out_x;
        cap = (k == 0) ? 4 : 2;
        hd  = m_mem[k][m_head[k]];
        if (do_check) begin
            chk($sformatf("d%0d_occupancy", k), occ, m_cnt[k]);
            if (m_cnt[k] == 0) chk($sformatf("d%0d_valid_when_empty", k), int'(ov), 0);
            if (ov) begin
                chk($sformatf("d%0d_head_data", k), int'(od), int'(hd[31:0]));
                chk($sformatf("d%0d_head_ctrl", k), int'(oc), int'(hd[35:32]));
            end else begin
                chk($sformatf("d%0d_ctrl_masked", k), int'(oc), 0);
            end
            if (m_in_rst[k]) chk($sformatf("d%0d_ready_in_reset", k), int'(ir), 0);
            else if (m_exp_rdy[k]) chk($sformatf("d%0d_ready_after_clear", k), int'(ir), 1);
            else if (m_cnt[k] == cap) chk($sformatf("d%0d_ready_when_full", k), int'(ir), 0);
        end
        // Apply the transfers that the coming rising edge will perform.
        in_x  = in_valid && ir;
        out_x = ov && out_ready;
        if (!rst) begin
            m_cnt[k]     = 0;
            m_head[k]    = 0;
            m_in_rst[k]  = 1'b1;
            m_exp_rdy[k] = 1'b0;
        end else if (flush) begin
            m_cnt[k]     = 0;
            m_in_rst[k]  = 1'b0;
            m_exp_rdy[k] = 1'b1;
        end else begin
            m_exp_rdy[k] = m_in_rst[k];
            m_in_rst[k]  = 1'b0;
            if (out_x) begin
                m_head[k] = (m_head[k] + 1) % 16;
                m_cnt[k]  = m_cnt[k] - 1;
            end
            if (in_x) begin
                m_mem[k][(m_head[k] + m_cnt[k]) % 16] = {in_ctrl, in_data};
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, m_started, ov2, od2, oc2, int'(occ2), ir2);
        model_step(1, m_started, ov1, od1, oc1, int'(occ1), ir1);
        m_started = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   idx;
        logic rdy;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA;
        in_ctrl = 4'hF; out_ready = 1'b1;

        // Reset held with in_valid asserted.
        repeat (3) tick();
        chk("rst_out_valid", int'(ov2), 0);
        chk("rst_occupancy", int'(occ2), 0);
        chk("rst_in_ready", int'(ir2), 0);
        chk("rst_in_ready_d1", int'(ir1), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("release_in_ready", int'(ir2), 1);
        chk("release_occupancy", int'(occ2), 0);

        // Streaming: latency 2 on DEPTH=2, 1 on DEPTH=1.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000 + i;
            in_ctrl  = 4'b0011;
            tick();
            if (i == 0) begin
                chk("stream_first_empty", int'(ov2), 0);
            end else begin
                chk("stream_valid", int'(ov2), 1);
                chk("stream_data", int'(od2), 32'h1000 + i - 1);
                chk("stream_ctrl", int'(oc2), 3);
                chk("stream_occupancy", int'(occ2), 2);
            end
            chk("stream_d1_data", int'(od1), 32'h1000 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_tail_data", int'(od2), 32'h1007);
        chk("stream_tail_occ", int'(occ2), 1);
        tick();
        chk("stream_drained", int'(ov2), 0);

        // Stall fill: only 4 beats fit in DEPTH=2.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h2000 + idx;
            in_ctrl  = 4'b0101;
            rdy = ir2;
            tick();
            if (rdy) idx++;
        end
        chk("stall_accepted", idx, 4);
        chk("stall_in_ready", int'(ir2), 0);
        chk("stall_occupancy", int'(occ2), 4);
        chk("stall_head_data", int'(od2), 32'h2000);
        // DEPTH=1 is full here: simultaneous pop and refused push.
        chk("d1_full_occ", int'(occ1), 2);
        chk("d1_full_in_ready", int'(ir1), 0);
        chk("d1_full_head", int'(od1), 32'h2000);

        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            chk("drain_valid", int'(ov2), 1);
            chk("drain_data", int'(od2), 32'h2000 + r);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_data  = 32'h2000 + idx;
            end else begin
                in_valid = 1'b0;
            end
            rdy = ir2;
            tick();
            if (rdy && in_valid) idx++;
            if (r == 0) begin
                chk("d1_pop_occ", int'(occ1), 1);
                chk("d1_pop_head", int'(od1), 32'h2001);
            end
        end
        in_valid = 1'b0;
        chk("drain_all_pushed", idx, 6);
        chk("drain_empty", int'(ov2), 0);
        chk("drain_occupancy", int'(occ2), 0);
        repeat (2) tick();

        // Flush with 3 entries held and a beat offered in the same cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3000 + i;
            in_ctrl  = 4'b1001;
            tick();
        end
        chk("preflush_occupancy", int'(occ2), 3);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD;
        in_ctrl = 4'hF;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", int'(ov2), 0);
        chk("flush_out_ctrl", int'(oc2), 0);
        chk("flush_occupancy", int'(occ2), 0);
        chk("flush_in_ready", int'(ir2), 1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_no_dead", int'(ov2), 0);
        end
        in_valid = 1'b1;
        in_data = 32'h4000;
        in_ctrl = 4'b0010;
        tick();
        in_valid = 1'b0;
        chk("postflush_lat0", int'(ov2), 0);
        tick();
        chk("postflush_valid", int'(ov2), 1);
        chk("postflush_data", int'(od2), 32'h4000);
        chk("postflush_ctrl", int'(oc2), 2);
        tick();
        chk("postflush_gone", int'(ov2), 0);

        // Reset while stalled and full.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000 + idx;
            in_ctrl  = 4'b0111;
            rdy = ir2;
            tick();
            if (rdy) idx++;
        end
        chk("prerst_occupancy", int'(occ2), 4);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("midrst_out_valid", int'(ov2), 0);
        chk("midrst_out_ctrl", int'(oc2), 0);
        chk("midrst_out_data", int'(od2), 0);
        chk("midrst_occupancy", int'(occ2), 0);
        chk("midrst_in_ready", int'(ir2), 0);
        rst = 1'b1;
        tick();
        chk("postrst_in_ready", int'(ir2), 1);
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("postrst_no_stale", int'(ov2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
